// File: rtl/tap_chain_pkg.sv
// Shared definitions for the tap delay chain.
// State encodings and a constant-safe clog2 helper.
package tap_chain_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_FILLING = 2'd1,
      ST_FULL    = 2'd2
   } state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/tap_fill_ctrl.sv
// Fill counter, occupancy FSM and full flag for the chain.
// Counts accepted words, saturating at CHANNEL; flush wins.
module tap_fill_ctrl
   import tap_chain_pkg::*;
#(
   parameter int CHANNEL = 10,
   parameter int CNT_W   = 4
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid_i,
   input  logic             flush_i,
   output logic [CNT_W-1:0] fill_o,
   output logic             full_o,
   output state_e           state_o
);

   localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(CHANNEL);

   logic [CNT_W-1:0] fill_q, fill_d;
   state_e           state_q, state_d;

   // Register fill count and occupancy state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_q  <= '0;
         state_q <= ST_EMPTY;
      end else begin
         fill_q  <= fill_d;
         state_q <= state_d;
      end
   end

   // Next fill count and state; flush overrides an accepted word.
   always_comb begin
      fill_d  = fill_q;
      state_d = state_q;
      if (flush_i) begin
         fill_d  = '0;
         state_d = ST_EMPTY;
      end else if (in_valid_i) begin
         if (fill_q != FILL_MAX) fill_d = fill_q + CNT_W'(1);
         unique case (state_q)
            ST_EMPTY:   state_d = ST_FILLING;
            ST_FILLING: if (fill_d == FILL_MAX) state_d = ST_FULL;
            ST_FULL:    state_d = ST_FULL;
            default:    state_d = ST_EMPTY;
         endcase
      end
   end

   assign fill_o  = fill_q;
   assign full_o  = (state_q == ST_FULL);
   assign state_o = state_q;

endmodule

// File: rtl/tap_delay_chain.sv
// Parametrised input shift chain with qualified shift,
// run-time tap select, synchronous flush and fill tracking.
module tap_delay_chain
   import tap_chain_pkg::*;
#(
   parameter  int WIDTH   = 32,
   parameter  int CHANNEL = 10,
   localparam int SEL_W   = clog2(CHANNEL),
   localparam int CNT_W   = clog2(CHANNEL + 1)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in,
   input  logic             flush,
   input  logic [SEL_W-1:0] tap_sel,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic [CNT_W-1:0] fill,
   output logic             full,
   output logic [1:0]       state
);

   logic [WIDTH-1:0] s_q [CHANNEL];
   logic [WIDTH-1:0] s_d [CHANNEL];
   logic [WIDTH-1:0] out_q, out_d;
   logic             out_valid_q, out_valid_d;
   logic [CNT_W-1:0] fill_w;
   logic             full_w;
   state_e           state_w;

   tap_fill_ctrl #(
      .CHANNEL (CHANNEL),
      .CNT_W   (CNT_W)
   ) u_fill (
      .clk        (clk),
      .rst        (rst),
      .in_valid_i (in_valid),
      .flush_i    (flush),
      .fill_o     (fill_w),
      .full_o     (full_w),
      .state_o    (state_w)
   );

   // Next stage contents: flush clears, accepted word shifts in.
   always_comb begin
      for (int k = 0; k < CHANNEL; k++) s_d[k] = s_q[k];
      if (flush) begin
         for (int k = 0; k < CHANNEL; k++) s_d[k] = '0;
      end else if (in_valid) begin
         s_d[0] = in;
         for (int k = 1; k < CHANNEL; k++) s_d[k] = s_q[k-1];
      end
   end

   // Tap mux on pre-edge contents; out-of-range taps read as empty.
   always_comb begin
      out_d       = '0;
      out_valid_d = 1'b0;
      for (int k = 0; k < CHANNEL; k++) begin
         if (32'(tap_sel) == k) out_d = s_q[k];
      end
      if (32'(tap_sel) < CHANNEL) begin
         out_valid_d = (CNT_W'(tap_sel) < fill_w);
      end
   end

   // Stage array and registered tap output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < CHANNEL; k++) s_q[k] <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         for (int k = 0; k < CHANNEL; k++) s_q[k] <= s_d[k];
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign fill      = fill_w;
   assign full      = full_w;
   assign state     = state_w;

endmodule

// File: tb/tb_tap_delay_chain.sv
// Directed bench for tap_delay_chain: a 4x8 instance and
// a 10x32 instance driven by hand-computed vectors.
module tb_tap_delay_chain;

   logic clk;
   logic rst;

   logic        a_vld, a_flush;
   logic [7:0]  a_in;
   logic [1:0]  a_sel;
   logic [7:0]  a_out;
   logic        a_ov;
   logic [2:0]  a_fill;
   logic        a_full;
   logic [1:0]  a_state;

   logic        b_vld, b_flush;
   logic [31:0] b_in;
   logic [3:0]  b_sel;
   logic [31:0] b_out;
   logic        b_ov;
   logic [3:0]  b_fill;
   logic        b_full;
   logic [1:0]  b_state;

   int n_cmp;
   int n_err;

   tap_delay_chain #(.WIDTH(8), .CHANNEL(4)) dut_a (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (a_vld),
      .in        (a_in),
      .flush     (a_flush),
      .tap_sel   (a_sel),
      .out       (a_out),
      .out_valid (a_ov),
      .fill      (a_fill),
      .full      (a_full),
      .state     (a_state)
   );

   tap_delay_chain #(.WIDTH(32), .CHANNEL(10)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (b_vld),
      .in        (b_in),
      .flush     (b_flush),
      .tap_sel   (b_sel),
      .out       (b_out),
      .out_valid (b_ov),
      .fill      (b_fill),
      .full      (b_full),
      .state     (b_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      a_vld = 0; a_flush = 0; a_in = '0; a_sel = '0;
      b_vld = 0; b_flush = 0; b_in = '0; b_sel = '0;
      tick();
      tick();
      chk("rst_out", 32'(a_out), 32'h0);
      chk("rst_state", 32'(a_state), 32'd0);
      rst = 1'b0;

      // fill A with 11,22,33,44
      a_vld = 1; a_in = 8'h11; tick();
      a_in = 8'h22; tick();
      a_in = 8'h33; tick();
      a_in = 8'h44; tick();
      a_vld = 0; a_sel = 2'd3; tick();
      chk("fill_out3", 32'(a_out), 32'h11);
      chk("fill_ov3", 32'(a_ov), 32'd1);
      chk("fill_cnt", 32'(a_fill), 32'd4);
      chk("fill_full", 32'(a_full), 32'd1);
      chk("fill_state", 32'(a_state), 32'd2);
      a_sel = 2'd0; tick();
      chk("tap0_out", 32'(a_out), 32'h44);
      chk("tap0_ov", 32'(a_ov), 32'd1);

      // overflow: push 55, oldest 11 dropped
      a_vld = 1; a_in = 8'h55; a_sel = 2'd3; tick();
      chk("ovf_pre", 32'(a_out), 32'h11);
      a_vld = 0; tick();
      chk("ovf_out3", 32'(a_out), 32'h22);
      chk("ovf_fill", 32'(a_fill), 32'd4);
      chk("ovf_state", 32'(a_state), 32'd2);

      // async reset with chain full, checked before any edge
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("arst_out", 32'(a_out), 32'h0);
      chk("arst_ov", 32'(a_ov), 32'd0);
      chk("arst_fill", 32'(a_fill), 32'd0);
      chk("arst_full", 32'(a_full), 32'd0);
      chk("arst_state", 32'(a_state), 32'd0);
      tick();
      rst = 1'b0;
      a_sel = 2'd0; tick();
      chk("post_rst_ov", 32'(a_ov), 32'd0);
      chk("post_rst_out", 32'(a_out), 32'h0);

      // gapped valid: A1, idle, A2
      a_vld = 1; a_in = 8'hA1; tick();
      chk("gap_state1", 32'(a_state), 32'd1);
      a_vld = 0; a_in = 8'hEE; tick();
      a_vld = 1; a_in = 8'hA2; tick();
      a_vld = 0;
      chk("gap_fill", 32'(a_fill), 32'd2);
      a_sel = 2'd2; tick();
      chk("part_out2", 32'(a_out), 32'h0);
      chk("part_ov2", 32'(a_ov), 32'd0);
      a_sel = 2'd1; tick();
      chk("part_out1", 32'(a_out), 32'hA1);
      chk("part_ov1", 32'(a_ov), 32'd1);

      // flush colliding with a valid word
      a_sel = 2'd0; a_flush = 1; a_vld = 1; a_in = 8'h77; tick();
      chk("fl_out_n1", 32'(a_out), 32'hA2);
      chk("fl_ov_n1", 32'(a_ov), 32'd1);
      chk("fl_fill", 32'(a_fill), 32'd0);
      chk("fl_state", 32'(a_state), 32'd0);
      chk("fl_full", 32'(a_full), 32'd0);
      a_flush = 0; a_vld = 0; tick();
      chk("fl_out_n2", 32'(a_out), 32'h0);
      chk("fl_ov_n2", 32'(a_ov), 32'd0);

      // B: 10 stages, 12 pushes of 1..12
      for (int i = 1; i <= 12; i++) begin
         b_vld = 1; b_in = 32'(i); tick();
      end
      b_vld = 0;
      chk("b_fill", 32'(b_fill), 32'd10);
      chk("b_full", 32'(b_full), 32'd1);
      b_sel = 4'd9; tick();
      chk("b_out9", b_out, 32'd3);
      chk("b_ov9", 32'(b_ov), 32'd1);
      b_sel = 4'd4; tick();
      chk("b_out4", b_out, 32'd8);
      b_sel = 4'd12; tick();
      chk("b_out12", b_out, 32'd0);
      chk("b_ov12", 32'(b_ov), 32'd0);
      b_sel = 4'd10; tick();
      chk("b_ov10", 32'(b_ov), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
